// File: rtl/leaf_pkt_pkg.sv
// Shared packet layout helpers, freespace-update port code and transmitter state encoding
// for the leaf credit transmitter.
package leaf_pkt_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    HOLD  = 2'd3
  } tx_state_e;

  // Port field value that marks a packet as a freespace (credit return) update.
  localparam int UPDATE_PORT_CODE = 1;

  // Fields are packed from the MSB down: valid, leaf, port; the payload sits at the LSB end.
  function automatic int validPos(input int packetBits);
    return packetBits - 1;
  endfunction

  function automatic int leafLsb(input int packetBits, input int leafBits);
    return packetBits - 1 - leafBits;
  endfunction

  function automatic int portLsb(input int packetBits, input int leafBits, input int portBits);
    return packetBits - 1 - leafBits - portBits;
  endfunction

endpackage

// File: rtl/credit_counter.sv
// Credit bookkeeping for the transmitter: consume on send, replenish on freespace update,
// saturate at the remote buffer depth and flag any overflow until reset.
module credit_counter #(
  parameter int NUM_BRAM_ADDR_BITS    = 7,
  parameter int FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        load_i,
  input  logic                        dec_i,
  input  logic                        inc_i,
  output logic [NUM_BRAM_ADDR_BITS:0] credits_o,
  output logic [NUM_BRAM_ADDR_BITS:0] creditsNext_o,
  output logic                        overflow_o
);

  localparam int CW = NUM_BRAM_ADDR_BITS + 1;
  localparam logic [CW:0] MAX_CREDITS = (CW+1)'(2 ** NUM_BRAM_ADDR_BITS);
  localparam logic [CW:0] UPDATE_STEP = (CW+1)'(FREESPACE_UPDATE_SIZE);

  logic [CW-1:0] credits_q, credits_d;
  logic          overflow_q, overflow_d;
  logic [CW:0]   sum;

  // One extra bit of headroom so an update on a nearly full count is seen before saturating.
  always_comb begin
    sum        = {1'b0, credits_q} + (inc_i ? UPDATE_STEP : '0) - {{CW{1'b0}}, dec_i};
    credits_d  = credits_q;
    overflow_d = overflow_q;
    if (load_i) begin
      credits_d = MAX_CREDITS[CW-1:0];
    end else if (sum > MAX_CREDITS) begin
      credits_d  = MAX_CREDITS[CW-1:0];
      overflow_d = 1'b1;
    end else begin
      credits_d = sum[CW-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credits_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      credits_q  <= credits_d;
      overflow_q <= overflow_d;
    end
  end

  assign credits_o     = credits_q;
  assign creditsNext_o = credits_d;
  assign overflow_o    = overflow_q;

endmodule

// File: rtl/leaf_credit_tx.sv
// Credit-based packet transmitter: wraps user payloads into network packets for one
// destination leaf/port and only sends while the remote input buffer has free space.
module leaf_credit_tx
  import leaf_pkt_pkg::*;
#(
  parameter int PACKET_BITS           = 97,
  parameter int NUM_LEAF_BITS         = 6,
  parameter int NUM_PORT_BITS         = 4,
  parameter int PAYLOAD_BITS          = 64,
  parameter int NUM_BRAM_ADDR_BITS    = 7,
  parameter int FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_LEAF_BITS-1:0]    cfg_dst_leaf,
  input  logic [NUM_PORT_BITS-1:0]    cfg_dst_port,
  input  logic [PAYLOAD_BITS-1:0]     din,
  input  logic                        vld_user2tx,
  output logic                        ack_tx2user,
  output logic [PACKET_BITS-1:0]      stream_out,
  input  logic                        resend,
  input  logic [PACKET_BITS-1:0]      stream_in,
  output logic [NUM_BRAM_ADDR_BITS:0] credits,
  output logic                        err_overflow
);

  localparam int VALID_POS = validPos(PACKET_BITS);
  localparam int LEAF_LSB  = leafLsb(PACKET_BITS, NUM_LEAF_BITS);
  localparam int PORT_LSB  = portLsb(PACKET_BITS, NUM_LEAF_BITS, NUM_PORT_BITS);

  tx_state_e                   state_q, state_d;
  logic [PACKET_BITS-1:0]      streamOut_q, streamOut_d;
  logic [NUM_BRAM_ADDR_BITS:0] creditsNext;
  logic                        outValid;
  logic                        transfer;
  logic                        update;
  logic                        unusedStreamIn;

  assign outValid    = streamOut_q[VALID_POS];
  assign ack_tx2user = (state_q == RUN) && (credits != '0) && !resend;
  assign transfer    = vld_user2tx && ack_tx2user;

  // Only updates addressed to our destination port return credits; INIT owns the count.
  assign update = (state_q != INIT) && stream_in[VALID_POS]
                  && (stream_in[PORT_LSB +: NUM_PORT_BITS] == NUM_PORT_BITS'(UPDATE_PORT_CODE))
                  && (stream_in[NUM_PORT_BITS-1:0] == cfg_dst_port);
  assign unusedStreamIn = ^stream_in;

  credit_counter #(
    .NUM_BRAM_ADDR_BITS   (NUM_BRAM_ADDR_BITS),
    .FREESPACE_UPDATE_SIZE(FREESPACE_UPDATE_SIZE)
  ) u_credit_counter (
    .clk          (clk),
    .reset        (reset),
    .load_i       (state_q == INIT),
    .dec_i        (transfer),
    .inc_i        (update),
    .credits_o    (credits),
    .creditsNext_o(creditsNext),
    .overflow_o   (err_overflow)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:  state_d = RUN;
      RUN: begin
        if (resend && outValid)        state_d = HOLD;
        else if (creditsNext == '0)    state_d = STALL;
      end
      STALL: begin
        if (resend && outValid)        state_d = HOLD;
        else if (creditsNext != '0)    state_d = RUN;
      end
      HOLD: begin
        if (!resend)                   state_d = (creditsNext == '0) ? STALL : RUN;
      end
      default: state_d = INIT;
    endcase
  end

  // A refused packet stays on the wire untouched; ack is low then, so no new packet competes.
  always_comb begin
    streamOut_d = '0;
    if (resend && outValid) begin
      streamOut_d = streamOut_q;
    end else if (transfer) begin
      streamOut_d[VALID_POS]                  = 1'b1;
      streamOut_d[LEAF_LSB +: NUM_LEAF_BITS]  = cfg_dst_leaf;
      streamOut_d[PORT_LSB +: NUM_PORT_BITS]  = cfg_dst_port;
      streamOut_d[PAYLOAD_BITS-1:0]           = din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= INIT;
      streamOut_q <= '0;
    end else begin
      state_q     <= state_d;
      streamOut_q <= streamOut_d;
    end
  end

  assign stream_out = streamOut_q;

endmodule

// File: tb/tb_leaf_credit_tx.sv
// Self-checking bench for leaf_credit_tx: a cycle model of credits/ack/valid plus a scoreboard
// of expected packets pushed on each accepted payload and popped when the network accepts it.
module tb_leaf_credit_tx;

  localparam logic [5:0] CFG_LEAF   = 6'h15;
  localparam logic [3:0] CFG_PORT   = 4'h9;
  localparam logic [3:0] OTHER_PORT = 4'h3;
  localparam int         MAX_CRED   = 128;
  localparam int         UPD_STEP   = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] dinR = '0;
  logic        vldR = 1'b0;
  logic        resendR = 1'b0;
  logic [96:0] streamInR = '0;
  logic        ack_tx2user;
  logic [96:0] stream_out;
  logic [7:0]  credits;
  logic        err_overflow;

  int assertCount = 0;
  int failCount   = 0;

  logic [96:0] sb[$];
  int   mCredits = 0;
  bit   mErr = 1'b0;
  bit   mInit = 1'b0;
  bit   mValid = 1'b0;
  bit   mHold = 1'b0;

  leaf_credit_tx dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_dst_leaf(CFG_LEAF),
    .cfg_dst_port(CFG_PORT),
    .din         (dinR),
    .vld_user2tx (vldR),
    .ack_tx2user (ack_tx2user),
    .stream_out  (stream_out),
    .resend      (resendR),
    .stream_in   (streamInR),
    .credits     (credits),
    .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // kind: 0 idle, 1 matching update, 2 update for another port, 3 wrong port code
  function automatic logic [96:0] makeStreamIn(input int kind);
    logic [96:0] p;
    p = '0;
    if (kind != 0) begin
      p[96]    = 1'b1;
      p[95:90] = 6'h2A;
      p[89:86] = (kind == 3) ? 4'd2 : 4'd1;
      p[3:0]   = (kind == 2) ? OTHER_PORT : CFG_PORT;
    end
    return p;
  endfunction

  // Drives one cycle of inputs at a negedge, checks outputs mid-cycle, advances the model.
  task automatic applyStimulus(input logic vldIn, input logic [63:0] dataIn, input logic resendIn, input int updKind);
    logic expAck, xfer, upd, nValid, nHold;
    int   nCred;
    vldR      = vldIn;
    dinR      = dataIn;
    resendR   = resendIn;
    streamInR = makeStreamIn(updKind);
    #1;
    expAck = mInit && !mHold && (mCredits != 0) && !resendIn;
    xfer   = vldIn && expAck;
    upd    = mInit && (updKind == 1);
    checkOutput("ack", ack_tx2user, expAck);
    checkOutput("credits", credits, mCredits);
    checkOutput("err", err_overflow, mErr);
    checkOutput("valid", stream_out[96], mValid);
    if (mValid) begin
      if (sb.size() == 0) checkOutput("sbDepth", sb.size(), 1);
      else begin
        checkOutput("pkt", stream_out, sb[0]);
        if (!resendIn) void'(sb.pop_front());
      end
    end
    if (xfer) sb.push_back({1'b1, CFG_LEAF, CFG_PORT, 22'b0, dataIn});
    if (!mInit) begin
      nCred = MAX_CRED;
    end else begin
      nCred = mCredits - int'(xfer) + (upd ? UPD_STEP : 0);
      if (nCred > MAX_CRED) begin
        nCred = MAX_CRED;
        mErr  = 1'b1;
      end
    end
    nValid = xfer || (resendIn && mValid);
    nHold  = resendIn && mValid;
    @(negedge clk);
    mCredits = nCred;
    mInit    = 1'b1;
    mValid   = nValid;
    mHold    = nHold;
  endtask

  task automatic resetDut(input bit checkAsync);
    reset     = 1'b1;
    vldR      = 1'b0;
    resendR   = 1'b0;
    streamInR = '0;
    if (checkAsync) begin
      #2;
      checkOutput("rstAsyncStream", stream_out, 0);
      checkOutput("rstAsyncAck", ack_tx2user, 0);
    end
    @(negedge clk);
    @(negedge clk);
    checkOutput("rstStream", stream_out, 0);
    checkOutput("rstCredits", credits, 0);
    checkOutput("rstErr", err_overflow, 0);
    checkOutput("rstAck", ack_tx2user, 0);
    mCredits = 0;
    mErr     = 1'b0;
    mInit    = 1'b0;
    mValid   = 1'b0;
    mHold    = 1'b0;
    sb.delete();
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    resetDut(1'b0);

    applyStimulus(1'b0, '0, 1'b0, 0);
    checkOutput("initCredits", credits, MAX_CRED);
    checkOutput("initAck", ack_tx2user, 1);

    for (int i = 0; i < 128; i++) applyStimulus(1'b1, {$urandom, $urandom}, 1'b0, 0);
    checkOutput("drainCredits", credits, 0);
    checkOutput("drainAck", ack_tx2user, 0);

    applyStimulus(1'b1, {$urandom, $urandom}, 1'b0, 2);
    checkOutput("otherPort", credits, 0);
    applyStimulus(1'b1, {$urandom, $urandom}, 1'b0, 3);
    checkOutput("wrongCode", credits, 0);
    applyStimulus(1'b0, '0, 1'b0, 1);
    checkOutput("updCredits", credits, 64);
    checkOutput("updAck", ack_tx2user, 1);

    for (int i = 0; i < 54; i++) applyStimulus(1'b1, {$urandom, $urandom}, 1'b0, 0);
    checkOutput("tenCredits", credits, 10);
    applyStimulus(1'b1, {$urandom, $urandom}, 1'b0, 1);
    checkOutput("sameCycle", credits, 73);

    applyStimulus(1'b1, 64'hDEAD_BEEF_0123_4567, 1'b0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, {$urandom, $urandom}, 1'b1, 0);
    checkOutput("holdCredits", credits, 72);
    applyStimulus(1'b1, {$urandom, $urandom}, 1'b0, 0);
    applyStimulus(1'b1, 64'h0F0F_0F0F_A5A5_A5A5, 1'b0, 0);
    checkOutput("afterHold", credits, 71);

    for (int i = 0; i < 35; i++) applyStimulus(1'b1, {$urandom, $urandom}, 1'b0, 0);
    applyStimulus(1'b0, '0, 1'b0, 1);
    checkOutput("hundred", credits, 100);
    applyStimulus(1'b0, '0, 1'b0, 1);
    checkOutput("satCredits", credits, MAX_CRED);
    checkOutput("errSet", err_overflow, 1);
    applyStimulus(1'b0, '0, 1'b0, 0);
    applyStimulus(1'b0, '0, 1'b0, 0);
    checkOutput("errSticky", err_overflow, 1);

    applyStimulus(1'b1, {$urandom, $urandom}, 1'b0, 0);
    applyStimulus(1'b0, '0, 1'b1, 0);
    applyStimulus(1'b1, '0, 1'b1, 0);
    resetDut(1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b0, 0);
    checkOutput("postRstCredits", credits, MAX_CRED);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
